vec_lane_collector: RTL and testbench

- Issue side and result-collection side of the 4-lane vector ALU array.
- Launches 1 to 4 lanes with single-cycle run pulses.
- Captures each lane's one-shot result (64-bit data, 10-bit register index, done pulse) into a per-lane holding register.
- Serialises the held results onto the single vector-register-file write port using round-robin arbitration with backpressure, then signals completion of the operation.

---
 rtl/vec_lane_collector.sv | 188 ++++++++++++++++++
 tb/tb_vec_lane_collector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_lane_collector.sv
// Issue and result-collection front end for the 4-lane vector ALU array.
// Optional watchdog on result collection: define VEC_COLLECT_TIMEOUT_EN.
module vec_lane_collector #(
  parameter logic [9:0]  VLEN           = 10'd128,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  nb_lanes,
  output logic        busy,
  output logic        run0,
  output logic        run1,
  output logic        run2,
  output logic        run3,
  input  logic [63:0] vd0,
  input  logic [63:0] vd1,
  input  logic [63:0] vd2,
  input  logic [63:0] vd3,
  input  logic [9:0]  regi0,
  input  logic [9:0]  regi1,
  input  logic [9:0]  regi2,
  input  logic [9:0]  regi3,
  input  logic        done0,
  input  logic        done1,
  input  logic        done2,
  input  logic        done3,
  output logic        wr_en,
  output logic [9:0]  wr_index,
  output logic [63:0] wr_data,
  input  logic        wr_ready,
  output logic        op_done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, COLLECT, FINISH} state_t;

  state_t      state;
  logic [3:0]  expected, captured, written, hold_valid, run_q;
  logic [63:0] hold_data [4];
  logic [9:0]  hold_idx  [4];
  logic [1:0]  rr_ptr, wr_lane;

  logic [63:0] vd   [4];
  logic [9:0]  regi [4];
  logic [3:0]  done;

  logic        handshake, grant_found;
  logic [3:0]  hs_mask, avail, launch_mask;
  logic [1:0]  scan_base, grant_lane, lane;

`ifdef VEC_COLLECT_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        capture_any;
  assign capture_any = |(done & expected & ~captured);
`endif

  assign vd[0] = vd0;  assign vd[1] = vd1;  assign vd[2] = vd2;  assign vd[3] = vd3;
  assign regi[0] = regi0;  assign regi[1] = regi1;
  assign regi[2] = regi2;  assign regi[3] = regi3;
  assign done = {done3, done2, done1, done0};
  assign {run3, run2, run1, run0} = run_q;

  assign handshake = wr_en & wr_ready;
  assign hs_mask   = handshake ? (4'b0001 << wr_lane) : '0;
  assign avail     = hold_valid & ~hs_mask;
  // After a handshake the scan already starts past the lane just written.
  assign scan_base = handshake ? (wr_lane + 2'd1) : rr_ptr;

  always_comb begin
    grant_found = 1'b0;
    grant_lane  = scan_base;
    lane        = scan_base;
    for (int unsigned k = 0; k < 4; k++) begin
      lane = scan_base + 2'(k);
      if (!grant_found && avail[lane]) begin
        grant_found = 1'b1;
        grant_lane  = lane;
      end
    end
  end

  always_comb begin
    case (nb_lanes)
      2'd0:    launch_mask = 4'b0001;
      2'd1:    launch_mask = 4'b0011;
      2'd2:    launch_mask = 4'b0111;
      default: launch_mask = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      expected   <= '0;
      captured   <= '0;
      written    <= '0;
      hold_valid <= '0;
      run_q      <= '0;
      rr_ptr     <= '0;
      wr_lane    <= '0;
      wr_en      <= 1'b0;
      wr_index   <= '0;
      wr_data    <= '0;
      op_done    <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
`ifdef VEC_COLLECT_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      run_q   <= '0;
      op_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            expected   <= launch_mask;
            captured   <= '0;
            written    <= '0;
            hold_valid <= '0;
            err        <= 1'b0;
            run_q      <= launch_mask;
            busy       <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (|done) err <= 1'b1;
`ifdef VEC_COLLECT_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= COLLECT;
        end
        COLLECT: begin
          if (handshake) begin
            hold_valid[wr_lane] <= 1'b0;
            written[wr_lane]    <= 1'b1;
            rr_ptr              <= wr_lane + 2'd1;
          end
          for (int unsigned i = 0; i < 4; i++) begin
            if (done[i]) begin
              if (expected[i] && !captured[i]) begin
                hold_data[i]  <= vd[i];
                hold_idx[i]   <= regi[i];
                hold_valid[i] <= 1'b1;
                captured[i]   <= 1'b1;
                if ((regi[i] >= 10'd32) || (regi[i] >= VLEN)) err <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          if (!wr_en || handshake) begin
            wr_en <= grant_found;
            if (grant_found) begin
              wr_index <= hold_idx[grant_lane];
              wr_data  <= hold_data[grant_lane];
              wr_lane  <= grant_lane;
            end
          end
`ifdef VEC_COLLECT_TIMEOUT_EN
          if (capture_any) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TIMEOUT_CYCLES) begin
            err      <= 1'b1;
            expected <= captured;
          end else if (captured != expected) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
          // Completion looks ahead through this edge's handshake so op_done
          // lands in the cycle right after the last write.
          if ((written | hs_mask) == expected) begin
            state   <= FINISH;
            op_done <= 1'b1;
            busy    <= 1'b0;
          end
        end
        FINISH: begin
          if (|done) err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_lane_collector.sv
// Self-checking bench for vec_lane_collector: directed scenarios followed by
// randomized operations checked against a set-based model of the writes.
module tb_vec_lane_collector;

  logic        clk = 1'b0;
  logic        reset, start, wr_ready;
  logic [1:0]  nb_lanes;
  logic        busy, run0, run1, run2, run3, wr_en, op_done, err;
  logic [9:0]  wr_index;
  logic [63:0] wr_data;
  logic [63:0] vd_a   [4];
  logic [9:0]  regi_a [4];
  logic [3:0]  done_a;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  logic [9:0]  obs_idx  [$];
  logic [63:0] obs_data [$];
  int unsigned obs_cyc  [$];
  int          opdone_cnt = 0;
  int unsigned opdone_cyc = 0;
  logic        busy_at_done = 1'b1;

  vec_lane_collector #(.VLEN(10'd128), .TIMEOUT_CYCLES(16'd1024)) dut (
    .clk(clk), .reset(reset), .start(start), .nb_lanes(nb_lanes), .busy(busy),
    .run0(run0), .run1(run1), .run2(run2), .run3(run3),
    .vd0(vd_a[0]), .vd1(vd_a[1]), .vd2(vd_a[2]), .vd3(vd_a[3]),
    .regi0(regi_a[0]), .regi1(regi_a[1]), .regi2(regi_a[2]), .regi3(regi_a[3]),
    .done0(done_a[0]), .done1(done_a[1]), .done2(done_a[2]), .done3(done_a[3]),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data), .wr_ready(wr_ready),
    .op_done(op_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  // One clock cycle: log what the DUT presents now, then advance past the edge.
  task automatic step();
    if (wr_en && wr_ready) begin
      obs_idx.push_back(wr_index);
      obs_data.push_back(wr_data);
      obs_cyc.push_back(cyc);
    end
    if (op_done) begin
      opdone_cnt++;
      opdone_cyc   = cyc;
      busy_at_done = busy;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_obs();
    obs_idx.delete();
    obs_data.delete();
    obs_cyc.delete();
    opdone_cnt   = 0;
    busy_at_done = 1'b1;
  endtask

  task automatic start_op(input logic [1:0] nb);
    int m;
    m = (1 << (int'(nb) + 1)) - 1;
    clear_obs();
    start    = 1'b1;
    nb_lanes = nb;
    step();
    start = 1'b0;
    check("run_mask", {run3, run2, run1, run0}, 64'(m));
    check("busy_launch", busy, 1);
    step();
    check("run_cleared", {run3, run2, run1, run0}, 0);
  endtask

  task automatic pulse(input logic [3:0] lanes);
    done_a = lanes;
    step();
    done_a = '0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && opdone_cnt == 0; i++) step();
    check("op_done_seen", 64'(opdone_cnt), 1);
  endtask

  int unsigned exp_rr [4];
  int unsigned delay  [4];
  logic [3:0]  seen, amask;
  logic        exp_err, bad, found;
  int          na;
  logic [63:0] d1;

  initial begin
    reset = 1'b1; start = 1'b0; nb_lanes = '0; wr_ready = 1'b1; done_a = '0;
    for (int i = 0; i < 4; i++) begin vd_a[i] = '0; regi_a[i] = '0; end
    @(posedge clk); #1;
    step();
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_op_done", op_done, 0);
    check("rst_err", err, 0);
    check("rst_run", {run3, run2, run1, run0}, 0);
    check("rst_wr_index", wr_index, 0);
    check("rst_wr_data", wr_data, 0);
    reset = 1'b0;
    step();

    // Parallel completion of all four lanes
    start_op(2'd3);
    for (int i = 0; i < 4; i++) begin
      regi_a[i] = 10'(4 + i);
      vd_a[i]   = 64'(10 + i);
    end
    pulse(4'hF);
    wait_done(30);
    check("par_nwrites", 64'(obs_idx.size()), 4);
    if (obs_idx.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("par_idx", obs_idx[i], 64'(4 + i));
        check("par_data", obs_data[i], 64'(10 + i));
        check("par_consec", 64'(obs_cyc[i] - obs_cyc[0]), 64'(i));
      end
      check("par_done_lat", 64'(opdone_cyc - obs_cyc[3]), 1);
    end
    check("par_busy_at_done", busy_at_done, 0);
    check("par_err", err, 0);
    step(); step();
    check("par_done_once", 64'(opdone_cnt), 1);

    // Backpressure with lane 1 finishing first; a start while busy is ignored
    start_op(2'd1);
    wr_ready  = 1'b0;
    regi_a[1] = 10'd9;
    d1        = {$urandom, $urandom};
    vd_a[1]   = d1;
    pulse(4'b0010);
    regi_a[0] = 10'd8;
    vd_a[0]   = {$urandom, $urandom};
    pulse(4'b0001);
    for (int k = 0; k < 3; k++) begin
      check("bp_wr_en", wr_en, 1);
      check("bp_index", wr_index, 9);
      check("bp_data", wr_data, d1);
      check("bp_no_run", {run3, run2, run1, run0}, 0);
      check("bp_busy", busy, 1);
      start    = (k == 1);
      nb_lanes = 2'd3;
      step();
      start = 1'b0;
    end
    check("bp_no_run_after", {run3, run2, run1, run0}, 0);
    wr_ready = 1'b1;
    wait_done(30);
    check("bp_nwrites", 64'(obs_idx.size()), 2);
    if (obs_idx.size() == 2) begin
      check("bp_first", obs_idx[0], 9);
      check("bp_second", obs_idx[1], 8);
      check("bp_second_data", obs_data[1], vd_a[0]);
    end
    step(); step();
    check("bp_done_once", 64'(opdone_cnt), 1);
    check("bp_err", err, 0);

    // Single lane with an unexpected done on lane 1
    start_op(2'd0);
    regi_a[0] = 10'd3;
    regi_a[1] = 10'd12;
    pulse(4'b0010);
    check("single_err_set", err, 1);
    pulse(4'b0001);
    wait_done(30);
    check("single_nwrites", 64'(obs_idx.size()), 1);
    if (obs_idx.size() == 1) check("single_idx", obs_idx[0], 3);
    step();
    check("single_err_sticky", err, 1);

    // Reset mid-operation with two holds valid
    start_op(2'd3);
    check("start_clears_err", err, 0);
    wr_ready  = 1'b0;
    regi_a[0] = 10'd16;
    regi_a[1] = 10'd17;
    pulse(4'b0011);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_wr_en", wr_en, 0);
    clear_obs();
    wr_ready  = 1'b1;
    regi_a[2] = 10'd18;
    pulse(4'b0100);
    for (int i = 0; i < 4; i++) step();
    check("rst_mid_no_write", 64'(obs_idx.size()), 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_no_done", 64'(opdone_cnt), 0);
    start_op(2'd0);
    regi_a[0] = 10'd20;
    vd_a[0]   = 64'h1234_5678_9abc_def0;
    pulse(4'b0001);
    wait_done(30);
    check("post_rst_nwrites", 64'(obs_idx.size()), 1);
    if (obs_idx.size() == 1) begin
      check("post_rst_idx", obs_idx[0], 20);
      check("post_rst_data", obs_data[0], 64'h1234_5678_9abc_def0);
    end

    // Round-robin: pointer left at 2 after lane 1, then lanes 0 and 3 pending
    start_op(2'd3);
    for (int i = 0; i < 4; i++) begin
      regi_a[i] = 10'(24 + i);
      vd_a[i]   = {$urandom, $urandom};
    end
    pulse(4'b0010);
    for (int i = 0; i < 10 && obs_idx.size() < 1; i++) step();
    pulse(4'b1001);
    for (int i = 0; i < 20 && obs_idx.size() < 3; i++) step();
    pulse(4'b0100);
    wait_done(30);
    exp_rr = '{25, 27, 24, 26};
    check("rr_nwrites", 64'(obs_idx.size()), 4);
    if (obs_idx.size() == 4)
      for (int i = 0; i < 4; i++) check("rr_order", obs_idx[i], 64'(exp_rr[i]));
    check("rr_err", err, 0);

    // Randomized operations: each active lane's result written exactly once
    for (int op = 0; op < 20; op++) begin
      nb_lanes = 2'($urandom_range(0, 3));
      na       = int'(nb_lanes) + 1;
      amask    = 4'((1 << na) - 1);
      exp_err  = 1'b0;
      for (int l = 0; l < 4; l++) begin
        delay[l]  = $urandom_range(0, 6);
        bad       = ($urandom_range(0, 7) == 0);
        regi_a[l] = 10'((bad ? 32 : 0) + l * 8 + int'($urandom_range(0, 7)));
        vd_a[l]   = {$urandom, $urandom};
        if (bad && l < na) exp_err = 1'b1;
      end
      start_op(nb_lanes);
      for (int t = 0; t < 80 && opdone_cnt == 0; t++) begin
        for (int l = 0; l < 4; l++) done_a[l] = (l < na) && (delay[l] == t);
        wr_ready = ($urandom_range(0, 3) != 0);
        step();
        done_a = '0;
      end
      wr_ready = 1'b1;
      check("rnd_op_done", 64'(opdone_cnt), 1);
      check("rnd_nwrites", 64'(obs_idx.size()), 64'(na));
      seen = '0;
      for (int j = 0; j < obs_idx.size(); j++) begin
        found = 1'b0;
        for (int l = 0; l < na; l++) begin
          if (!found && regi_a[l] == obs_idx[j]) begin
            found = 1'b1;
            seen[l] = 1'b1;
            check("rnd_data", obs_data[j], vd_a[l]);
          end
        end
        check("rnd_idx_known", found, 1);
      end
      check("rnd_lanes_written", seen, amask);
      check("rnd_err", err, exp_err);
      check("rnd_busy_at_done", busy_at_done, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
